int_request_gen: RTL and testbench

INT_REQUEST_GEN -- requirements
Module: int_request_gen

---
 rtl/int_request_gen_if.sv | 13 +
 rtl/int_request_gen.sv | 195 +++++++++++++++++++
 tb/tb_int_request_gen.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/int_request_gen_if.sv
// CPU register/address bus seen by int_request_gen: chip select, direction,
// register select, data in/out and the full address used for vector-fetch detection.
interface int_request_gen_if;
  logic        CS;
  logic        RW;
  logic [1:0]  A;
  logic [7:0]  DI;
  logic [7:0]  DO;
  logic [15:0] ADDR;

  modport master (output CS, RW, A, DI, ADDR, input DO);
  modport slave  (input CS, RW, A, DI, ADDR, output DO);
endinterface

// File: rtl/int_request_gen.sv
// Interrupt request generator: edge-sampled maskable sources with IRQ level output,
// pulsed NMI with a 1-deep queue. Optional macro INT_REQUEST_GEN_AUTOACK_EN adds vector-fetch auto-clear.
module int_request_gen_lane (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic clr,
  output logic pend
);
  logic s_q, p_q, pend_q;
  logic s_d, p_d, pend_d;

  // set wins over a coincident write-1-clear
  always_comb begin
    s_d    = src;
    p_d    = s_q;
    pend_d = (pend_q & ~clr) | (s_q & ~p_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q    <= 1'b0;
      p_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      s_q    <= s_d;
      p_q    <= p_d;
      pend_q <= pend_d;
    end
  end

  assign pend = pend_q;
endmodule

module int_request_gen #(
  parameter int NSRC  = 8,
  parameter int NMI_W = 4
) (
  input  logic               PHI0,
  input  logic               _RES,
  input  logic [NSRC-1:0]    SRC,
  input  logic               NMI_SRC,
  int_request_gen_if.slave   bus,
  output logic               _IRQ,
  output logic               _NMI,
  output logic               VEC_ACK
);
  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} nmi_st_e;

  logic            wr_en;
  logic [NSRC-1:0] pend, clr;
  logic [7:0]      pend8, masked, active, rdata;
  logic            any_act;
  logic [2:0]      act_idx;

  logic [7:0] mask_q, mask_d;
  logic [1:0] ctrl_q, ctrl_d;
  logic       irq_n_q, irq_n_d;
  logic       vack_q, vack_d;
  logic       nmi_s_q, nmi_s_d, nmi_p_q, nmi_p_d;
  nmi_st_e    st_q, st_d;
  logic [3:0] cnt_q, cnt_d;
  logic       qf_q, qf_d;
  logic       nmie, nmi_req;

  assign wr_en = bus.CS & ~bus.RW;
  assign nmie  = ctrl_q[1];

  int_request_gen_lane u_lane [NSRC-1:0] (
    .clk   (PHI0),
    .rst_n (_RES),
    .src   (SRC),
    .clr   (clr),
    .pend  (pend)
  );

  always_comb begin
    pend8 = 8'h00;
    pend8[NSRC-1:0] = pend;
    masked = pend8 & mask_q;
  end

  // lowest-index active source wins: scan from the top down
  always_comb begin
    act_idx = 3'd0;
    any_act = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (masked[i]) begin
        act_idx = 3'(i);
        any_act = 1'b1;
      end
    end
    active = {any_act, 4'b0000, act_idx};
  end

  always_comb begin
    clr = (wr_en && bus.A == 2'd0) ? bus.DI[NSRC-1:0] : '0;
`ifdef INT_REQUEST_GEN_AUTOACK_EN
    if (bus.RW && bus.ADDR == 16'hFFFE && any_act)
      clr = clr | (NSRC'(1) << act_idx);
`endif
  end

  always_comb begin
    mask_d  = (wr_en && bus.A == 2'd1) ? bus.DI : mask_q;
    ctrl_d  = (wr_en && bus.A == 2'd2) ? bus.DI[1:0] : ctrl_q;
    irq_n_d = ~(ctrl_q[0] & (|masked));
    vack_d  = bus.RW && (bus.ADDR == 16'hFFFA);
    nmi_s_d = NMI_SRC;
    nmi_p_d = nmi_s_q;
  end

  always_comb begin
    case (bus.A)
      2'd0:    rdata = pend8;
      2'd1:    rdata = mask_q;
      2'd2:    rdata = {6'b0, ctrl_q};
      default: rdata = active;
    endcase
    bus.DO = (bus.CS && bus.RW) ? rdata : 8'h00;
  end

  // NMI sequencer: a request during PULSE/GAP is held in qf and replayed on GAP exit
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    qf_d    = qf_q;
    nmi_req = nmi_s_q & ~nmi_p_q & nmie;
    case (st_q)
      S_IDLE: begin
        if (nmi_req) begin
          st_d  = S_PULSE;
          cnt_d = 4'd0;
        end
      end
      S_PULSE: begin
        if (nmi_req) qf_d = 1'b1;
        if (cnt_q == 4'(NMI_W - 1)) begin
          st_d  = S_GAP;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_GAP: begin
        if (nmi_req) qf_d = 1'b1;
        if (cnt_q == 4'd1) begin
          cnt_d = 4'd0;
          if ((qf_q && nmie) || nmi_req) begin
            st_d = S_PULSE;
            qf_d = 1'b0;
          end else begin
            st_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        st_d  = S_IDLE;
        cnt_d = 4'd0;
      end
    endcase
    if (!nmie) qf_d = 1'b0;
  end

  always_ff @(posedge PHI0 or negedge _RES) begin
    if (!_RES) begin
      mask_q  <= 8'h00;
      ctrl_q  <= 2'b00;
      irq_n_q <= 1'b1;
      vack_q  <= 1'b0;
      nmi_s_q <= 1'b0;
      nmi_p_q <= 1'b0;
      st_q    <= S_IDLE;
      cnt_q   <= 4'd0;
      qf_q    <= 1'b0;
    end else begin
      mask_q  <= mask_d;
      ctrl_q  <= ctrl_d;
      irq_n_q <= irq_n_d;
      vack_q  <= vack_d;
      nmi_s_q <= nmi_s_d;
      nmi_p_q <= nmi_p_d;
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      qf_q    <= qf_d;
    end
  end

  // _NMI decodes straight from the state flop so reset releases it immediately
  assign _IRQ    = irq_n_q;
  assign _NMI    = (st_q != S_PULSE);
  assign VEC_ACK = vack_q;
endmodule

// File: tb/tb_int_request_gen.sv
// Scoreboard bench for int_request_gen: stimulus pushes expected values tagged with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_int_request_gen;
  logic       PHI0 = 1'b0;
  logic       res_n = 1'b1;
  logic [7:0] src = 8'h00;
  logic       nmi_src = 1'b0;
  logic       irq_n, nmi_n, vack;

  int_request_gen_if bus ();

  int_request_gen #(.NSRC(8), .NMI_W(4)) dut (
    .PHI0    (PHI0),
    ._RES    (res_n),
    .SRC     (src),
    .NMI_SRC (nmi_src),
    .bus     (bus),
    ._IRQ    (irq_n),
    ._NMI    (nmi_n),
    .VEC_ACK (vack)
  );

  always #5 PHI0 = ~PHI0;

  localparam int K_DO = 0, K_IRQ = 1, K_NMI = 2, K_VACK = 3;
`ifdef INT_REQUEST_GEN_AUTOACK_EN
  localparam logic [7:0] AUTO_EXP = 8'h08;
`else
  localparam logic [7:0] AUTO_EXP = 8'h09;
`endif

  typedef struct {
    int         due;
    int         kind;
    logic [7:0] val;
    string      nm;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  exp_t       mon_e;
  logic [7:0] mon_act;

  always @(posedge PHI0) cyc <= cyc + 1;

  always @(negedge PHI0) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      case (mon_e.kind)
        K_DO:    mon_act = bus.DO;
        K_IRQ:   mon_act = {7'b0, irq_n};
        K_NMI:   mon_act = {7'b0, nmi_n};
        default: mon_act = {7'b0, vack};
      endcase
      checks++;
      if (mon_e.due != cyc || mon_act !== mon_e.val) begin
        errors++;
        $display("FAIL %s: actual=%h required=%h cycle=%0d due=%0d",
                 mon_e.nm, mon_act, mon_e.val, cyc, mon_e.due);
      end
    end
  end

  task automatic push_exp(input int kind, input logic [7:0] val, input string nm);
    exp_t e;
    e.due  = cyc;
    e.kind = kind;
    e.val  = val;
    e.nm   = nm;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge PHI0);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.CS = 1'b1; bus.RW = 1'b0; bus.A = a; bus.DI = d;
    push_exp(K_DO, 8'h00, "do_idle_on_write");
    tick();
    bus.CS = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e, input string nm);
    bus.CS = 1'b1; bus.RW = 1'b1; bus.A = a;
    push_exp(K_DO, e, nm);
    tick();
    bus.CS = 1'b0; bus.RW = 1'b0;
  endtask

  logic [17:0] tab_src = 18'h00025;
  logic [17:0] tab_nmi = 18'h3F0C3;

  initial begin
    bus.CS = 1'b0; bus.RW = 1'b0; bus.A = 2'd0; bus.DI = 8'h00; bus.ADDR = 16'h0000;
    #1 res_n = 1'b0;
    tick(); tick();
    push_exp(K_IRQ, 8'h01, "irq_in_reset");
    push_exp(K_NMI, 8'h01, "nmi_in_reset");
    push_exp(K_VACK, 8'h00, "vack_in_reset");
    rd(2'd3, 8'h00, "active_in_reset");
    res_n = 1'b1;
    rd(2'd0, 8'h00, "pend_after_reset");
    rd(2'd1, 8'h00, "mask_after_reset");
    rd(2'd2, 8'h00, "ctrl_after_reset");
    wr(2'd2, 8'hFF);
    rd(2'd2, 8'h03, "ctrl_reserved_bits");
    wr(2'd2, 8'h01);
    wr(2'd1, 8'h04);

    // single source: PEND, then _IRQ one cycle later
    src = 8'h04;
    tick();
    push_exp(K_IRQ, 8'h01, "irq_before_pend");
    rd(2'd0, 8'h00, "pend_not_yet");
    push_exp(K_IRQ, 8'h01, "irq_one_cycle_lag");
    rd(2'd0, 8'h04, "pend_src2");
    push_exp(K_IRQ, 8'h00, "irq_asserted");
    rd(2'd3, 8'h82, "active_src2");

    // two sources, priority and write-1-clear
    src = 8'h24;
    tick(); tick();
    wr(2'd1, 8'hFF);
    rd(2'd0, 8'h24, "pend_src2_src5");
    wr(2'd0, 8'h04);
    push_exp(K_IRQ, 8'h00, "irq_still_low");
    rd(2'd0, 8'h20, "pend_after_w1c");
    rd(2'd3, 8'h85, "active_src5");
    wr(2'd0, 8'h20);
    push_exp(K_IRQ, 8'h00, "irq_hold_after_clear");
    tick();
    push_exp(K_IRQ, 8'h01, "irq_released");
    rd(2'd0, 8'h00, "pend_all_clear");

    // set edge coincident with write-1-clear
    src = 8'h26;
    tick();
    wr(2'd0, 8'h02);
    rd(2'd0, 8'h02, "set_beats_clear");
    wr(2'd0, 8'h02);
    rd(2'd0, 8'h00, "w1c_bit1");

    // vector-fetch auto-acknowledge (build dependent)
    src = 8'h2F;
    tick(); tick();
    rd(2'd0, 8'h09, "pend_09");
    rd(2'd3, 8'h80, "active_src0");
    bus.ADDR = 16'hFFFE; bus.RW = 1'b1;
    tick();
    bus.ADDR = 16'h0000; bus.RW = 1'b0;
    rd(2'd0, AUTO_EXP, "pend_after_fffe");

    // NMI vector fetch acknowledge
    bus.ADDR = 16'hFFFA; bus.RW = 1'b1;
    push_exp(K_VACK, 8'h00, "vack_before");
    tick();
    bus.ADDR = 16'h0000; bus.RW = 1'b0;
    push_exp(K_VACK, 8'h01, "vack_pulse");
    tick();
    push_exp(K_VACK, 8'h00, "vack_one_cycle");

    // NMI: pulse, queued pulse, third edge dropped
    wr(2'd2, 8'h03);
    for (int i = 0; i < 18; i++) begin
      nmi_src = tab_src[i];
      push_exp(K_NMI, {7'b0, tab_nmi[i]}, $sformatf("nmi_seq_%0d", i));
      tick();
    end

    // clearing NMIE drops the queue but finishes the current pulse
    nmi_src = 1'b1; tick();
    nmi_src = 1'b0; tick();
    push_exp(K_NMI, 8'h00, "nmi_pulse_c1");
    nmi_src = 1'b1; tick();
    nmi_src = 1'b0; tick();
    wr(2'd2, 8'h01);
    push_exp(K_NMI, 8'h00, "nmi_not_truncated");
    for (int i = 0; i < 8; i++) begin
      tick();
      push_exp(K_NMI, 8'h01, $sformatf("nmi_queue_dropped_%0d", i));
    end

    // reset in the middle of a pulse with a queued request
    wr(2'd2, 8'h03);
    nmi_src = 1'b1; tick();
    nmi_src = 1'b0; tick();
    push_exp(K_NMI, 8'h00, "nmi_before_reset");
    nmi_src = 1'b1; tick();
    nmi_src = 1'b0; tick();
    res_n = 1'b0;
    push_exp(K_NMI, 8'h01, "nmi_async_reset");
    push_exp(K_IRQ, 8'h01, "irq_async_reset");
    tick(); tick();
    res_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_exp(K_NMI, 8'h01, $sformatf("nmi_after_release_%0d", i));
      tick();
    end
    rd(2'd0, 8'h2F, "pend_src_high_at_release");

    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d required=0 leftover entries", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
